clk_div_n: RTL
==============

# clk_div_n

Parametrised, runtime-programmable clock divider, the successor to the fixed divide-by-3 counter. It generates a divided clock-level output and a one-cycle period tick from `clk` for any divisor from 2 to 2^WIDTH−1. Divisor changes are accepted at any time but take effect only at a period boundary, so `clk_div` never glitches or truncates a period. It sits beside the lab timing blocks as the common source of slow strobes and derived clock levels.

## Interface
Parameters:
- `WIDTH`, 8: width of the divisor and counter.
- `DEFAULT_DIV`, 3: divisor in force after reset. Legal range 2 .. 2^WIDTH−1.

Ports:
- `clk` input 1: the single clock; every register updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: count enable. When low, the counter and outputs hold.
- `div_in` input WIDTH: new divisor value.
- `div_load` input 1: single-cycle request to load `div_in`.
- `clk_div` output 1: registered divided-clock level.
- `tick` output 1: registered pulse, one cycle wide, once per period.
- `count` output WIDTH: current phase counter.
- `div_cur` output WIDTH: divisor currently in force.
- `pending` output 1: an accepted divisor is waiting for the next boundary.
- `div_err` output 1: one-cycle pulse when a load is rejected.

## Operation
- Internal registers: `count`, `div_cur`, `div_pend`, `pending`, `clk_div`, `tick`, `div_err`.
- Reset (`rst`=1 at an edge) has priority over all other inputs. It sets `count`=0, `div_cur`=DEFAULT_DIV, `pending`=0, `div_pend`=0, `clk_div`=0, `tick`=0 and `div_err`=0.
- `tick` and `div_err` default to 0 every non-reset cycle.
- Load handling is independent of `en`:
  - If `div_load`=1 and `div_in`<2: set `div_err`=1. `div_pend` and `pending` are unchanged.
  - If `div_load`=1 and `div_in`≥2: set `div_pend`=`div_in` and `pending`=1. A value already pending is overwritten, so the last load wins.
- Count with `en`=1:
  - If `count`==`div_cur`−1 (wrap): set `count`=0 and `tick`=1. If `pending` was 1 before this edge, also set `div_cur`=`div_pend` and clear `pending`.
  - Otherwise: `count`=`count`+1.
- Count with `en`=0: `count`, `div_cur` and `clk_div` hold, and `tick`=0.
- Load coincident with a wrap:
  - The wrap consumes only the value pending before the edge.
  - The new load sets `pending`=1 and `div_pend`=`div_in`; the load wins over the wrap's clear.
  - The new value is applied at the following wrap.
- Duty cycle, where D is the divisor in force after the edge: `clk_div` is 1 if next `count` < H, else 0, with H = (D>>1)+D[0] = ceil(D/2).
  - The high phase is ceil(D/2) cycles and the low phase is floor(D/2) cycles.
  - This gives exactly 50% duty for even D.
- Arithmetic: all compares are unsigned at WIDTH bits. `div_cur`−1 cannot underflow because `div_cur`≥2 always holds. No intermediate value exceeds WIDTH bits.
- `div_cur` changes only at a wrap, where `count`=0, so a shrinking divisor never leaves `count` out of range.

## Timing
- All outputs are registered, and every output change is visible one cycle after the causing edge.
- Steady state with `en`=1: `tick` is high for one cycle every D cycles, in the cycle after `count` wraps to 0. `tick` and the rising edge of `clk_div` coincide.
- First period after reset: `clk_div`=0 for the reset cycle, then follows the rule above. The first `tick` occurs D cycles after reset release.
- Load latency: `pending` rises the cycle after `div_load`. The new D takes effect at the first wrap whose edge is strictly later than the load edge.
- `div_err` is high for exactly the one cycle after a rejected load.
- `rst` mid-period discards any pending divisor. Counting restarts from 0 with DEFAULT_DIV.

## Test plan
- Reset, DEFAULT_DIV=3, `en`=1 held → over edges 1..6: `count`=1,2,0,1,2,0; `clk_div`=1,0,1,1,0,1; `tick`=1 only on edges 3 and 6.
- With `count`=1 at D=3, load 4 → `pending`=1 the next cycle, and `div_cur` stays 3 until the wrap. The wrap gives `div_cur`=4 and `pending`=0. The next period is 4 cycles, with `clk_div` 1,1,0,0.
- Load 1, then load 0 → `div_err` pulses one cycle each. `div_cur` and `pending` are unchanged, and the period stays 3.
- Drop `en` for 5 cycles at `count`=1 → `count`, `clk_div` and `div_cur` are frozen and `tick`=0. Counting resumes at 2 when `en` returns. A load during the hold still sets `pending`.
- Load 5 on the wrap edge, then load 6 and 7 on consecutive cycles → the wrap keeps the old D. The next wrap applies 7. With WIDTH=8, also load 255 → `clk_div` is high 128 cycles and low 127 cycles.
- Assert `rst` mid-period with `pending`=1 → next cycle `count`=0, `div_cur`=DEFAULT_DIV, `pending`=0 and `clk_div`=0. The first `tick` comes DEFAULT_DIV cycles after release.

Source files
------------

// File: rtl/clk_div_n.sv
// Runtime-programmable clock divider: divided clock level plus one-cycle period tick.
// A new divisor is staged in a pending slot and applied only at a period wrap.
module clk_div_n #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   output logic             clk_div,
   output logic             tick,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] div_cur,
   output logic             pending,
   output logic             div_err
);

   localparam logic [WIDTH-1:0] DEFAULT_DIV_C = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] ZERO_C        = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_C         = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] TWO_C         = {{(WIDTH-2){1'b0}}, 2'b10};

   // High-phase length ceil(d/2); never exceeds WIDTH bits for d <= 2^WIDTH-1.
   function automatic logic [WIDTH-1:0] high_len(input logic [WIDTH-1:0] d);
      return (d >> 1) + {{(WIDTH-1){1'b0}}, d[0]};
   endfunction

   logic [WIDTH-1:0] div_pend_r;
   logic [WIDTH-1:0] count_nxt_s;
   logic [WIDTH-1:0] div_nxt_s;
   logic             clk_div_nxt_s;
   logic             wrap_s;
   logic             load_ok_s;
   logic             load_bad_s;

   // Next-state computation for the phase counter, divisor and clock level.
   always_comb begin
      wrap_s        = 1'b0;
      count_nxt_s   = count;
      div_nxt_s     = div_cur;
      clk_div_nxt_s = clk_div;
      load_ok_s     = div_load && (div_in >= TWO_C);
      load_bad_s    = div_load && (div_in < TWO_C);
      if (en) begin
         if (count == (div_cur - ONE_C)) begin
            wrap_s      = 1'b1;
            count_nxt_s = ZERO_C;
            if (pending) begin
               div_nxt_s = div_pend_r;
            end else begin
               div_nxt_s = div_cur;
            end
         end else begin
            count_nxt_s = count + ONE_C;
         end
         clk_div_nxt_s = (count_nxt_s < high_len(div_nxt_s));
      end else begin
         count_nxt_s   = count;
         clk_div_nxt_s = clk_div;
      end
   end

   // State registers; a load in the wrap cycle re-arms pending after the wrap consumed the old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= ZERO_C;
         div_cur    <= DEFAULT_DIV_C;
         div_pend_r <= ZERO_C;
         pending    <= 1'b0;
         clk_div    <= 1'b0;
         tick       <= 1'b0;
         div_err    <= 1'b0;
      end else begin
         count   <= count_nxt_s;
         div_cur <= div_nxt_s;
         clk_div <= clk_div_nxt_s;
         tick    <= wrap_s;
         div_err <= load_bad_s;
         if (load_ok_s) begin
            div_pend_r <= div_in;
            pending    <= 1'b1;
         end else if (wrap_s && pending) begin
            div_pend_r <= div_pend_r;
            pending    <= 1'b0;
         end else begin
            div_pend_r <= div_pend_r;
            pending    <= pending;
         end
      end
   end

endmodule
